// File: rtl/cvfpu_client_pkg.sv
// Shared types, field widths and the free-tag search used by the FPU client.
// Optional build macro for the client: CVFPU_CLIENT_PERF_EN.
package cvfpu_client_pkg;

    localparam int OP_W      = 5;
    localparam int FMT_W     = 3;
    localparam int INT_FMT_W = 2;
    localparam int STATUS_W  = 5;
    localparam int SIMD_W    = 16;
    localparam int META_W    = 10;

    // Upper bound on the tag pool size that lowest_zero can search.
    localparam int MAX_TAGS  = 32;

    typedef struct packed {
        logic [4:0] warp;
        logic [4:0] rd;
    } meta_t;

    // Lowest index below n whose bit is clear; 0 when every bit is set.
    function automatic int lowest_zero(input logic [MAX_TAGS-1:0] vec, input int n);
        int idx;
        idx = 0;
        for (int i = MAX_TAGS - 1; i >= 0; i--) begin
            if (i < n && !vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cvfpu_tag_pool.sv
// Tag pool for the FPU client: in-flight bitmap, lowest-free allocation,
// free on response, flush, and per-tag writeback metadata storage.
module cvfpu_tag_pool
    import cvfpu_client_pkg::*;
#(
    parameter int  NUM_TAGS   = 4,
    parameter int  META_WIDTH = META_W,
    localparam int TAG_WIDTH  = $clog2(NUM_TAGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alloc_en,
    input  logic [META_WIDTH-1:0] alloc_meta,
    input  logic                  free_en,
    input  logic [TAG_WIDTH-1:0]  free_tag,
    output logic                  can_alloc,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    output logic                  free_hit,
    output logic [META_WIDTH-1:0] free_meta,
    output logic                  any_inflight
);

    logic [NUM_TAGS-1:0]   inflight;
    logic [META_WIDTH-1:0] meta_mem [NUM_TAGS];

    assign can_alloc    = ~&inflight;
    assign alloc_tag    = TAG_WIDTH'(lowest_zero(MAX_TAGS'(inflight), NUM_TAGS));
    assign free_hit     = inflight[free_tag];
    assign free_meta    = meta_mem[free_tag];
    assign any_inflight = |inflight;

    // Alloc and free never touch the same bit: the allocated tag was free
    // and the freed tag was busy, so both updates land in one cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            inflight <= '0;
        end else begin
            if (alloc_en)             inflight[alloc_tag] <= 1'b1;
            if (free_en && free_hit)  inflight[free_tag]  <= 1'b0;
        end
    end

    // NOTE: the metadata array has no reset; an entry is only read while its
    // inflight bit is set, and that bit is set by the same write that fills it.
    always_ff @(posedge clock) begin
        if (alloc_en) meta_mem[alloc_tag] <= alloc_meta;
    end

endmodule

// File: rtl/cvfpu_client.sv
// Initiator for the vector FPU req/resp interface: tags commands, registers
// results onto a writeback port, keeps sticky fflags. Macro: CVFPU_CLIENT_PERF_EN.
module cvfpu_client
    import cvfpu_client_pkg::*;
#(
    parameter int  WIDTH      = 512,
    parameter int  NUM_TAGS   = 4,
    parameter int  META_WIDTH = META_W,
    localparam int TAG_WIDTH  = $clog2(NUM_TAGS)
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WIDTH-1:0]      cmd_operands_0,
    input  logic [WIDTH-1:0]      cmd_operands_1,
    input  logic [WIDTH-1:0]      cmd_operands_2,
    input  logic [OP_W-1:0]       cmd_op,
    input  logic [2:0]            cmd_rm,
    input  logic [FMT_W-1:0]      cmd_src_fmt,
    input  logic [FMT_W-1:0]      cmd_dst_fmt,
    input  logic [INT_FMT_W-1:0]  cmd_int_fmt,
    input  logic [SIMD_W-1:0]     cmd_simd_mask,
    input  logic [META_WIDTH-1:0] cmd_meta,

    output logic                  fpu_req_valid,
    input  logic                  fpu_req_ready,
    output logic [WIDTH-1:0]      fpu_req_operands_0,
    output logic [WIDTH-1:0]      fpu_req_operands_1,
    output logic [WIDTH-1:0]      fpu_req_operands_2,
    output logic [OP_W-1:0]       fpu_req_op,
    output logic [2:0]            fpu_req_rm,
    output logic [FMT_W-1:0]      fpu_req_src_fmt,
    output logic [FMT_W-1:0]      fpu_req_dst_fmt,
    output logic [INT_FMT_W-1:0]  fpu_req_int_fmt,
    output logic [SIMD_W-1:0]     fpu_req_simd_mask,
    output logic [TAG_WIDTH-1:0]  fpu_req_tag,
    output logic                  fpu_flush,

    input  logic                  fpu_resp_valid,
    output logic                  fpu_resp_ready,
    input  logic [WIDTH-1:0]      fpu_resp_result,
    input  logic [STATUS_W-1:0]   fpu_resp_status,
    input  logic [TAG_WIDTH-1:0]  fpu_resp_tag,

    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [WIDTH-1:0]      wb_result,
    output logic [STATUS_W-1:0]   wb_status,
    output logic [META_WIDTH-1:0] wb_meta,

    input  logic                  flush,
    output logic [STATUS_W-1:0]   fflags,
    input  logic                  fflags_clear,
    output logic                  busy,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stall
);

    logic                  can_alloc;
    logic [TAG_WIDTH-1:0]  alloc_tag;
    logic                  tag_hit;
    logic [META_WIDTH-1:0] resp_meta;
    logic                  any_inflight;
    logic                  cmd_fire;
    logic                  resp_fire;
    logic                  resp_take;
    logic                  wb_fire;

    // Issue path is purely combinational; flush blocks new commands.
    assign fpu_req_valid = cmd_valid & can_alloc & ~flush;
    assign cmd_ready     = fpu_req_ready & can_alloc & ~flush;
    assign cmd_fire      = cmd_valid & cmd_ready;

    assign fpu_req_operands_0 = cmd_operands_0;
    assign fpu_req_operands_1 = cmd_operands_1;
    assign fpu_req_operands_2 = cmd_operands_2;
    assign fpu_req_op         = cmd_op;
    assign fpu_req_rm         = cmd_rm;
    assign fpu_req_src_fmt    = cmd_src_fmt;
    assign fpu_req_dst_fmt    = cmd_dst_fmt;
    assign fpu_req_int_fmt    = cmd_int_fmt;
    assign fpu_req_simd_mask  = cmd_simd_mask;
    assign fpu_req_tag        = alloc_tag;
    assign fpu_flush          = flush;

    assign fpu_resp_ready = ~wb_valid | wb_ready;
    assign resp_fire      = fpu_resp_valid & fpu_resp_ready;
    // Stray tags and responses landing in a flush cycle are dropped.
    assign resp_take      = resp_fire & tag_hit & ~flush;
    assign wb_fire        = wb_valid & wb_ready;

    cvfpu_tag_pool #(
        .NUM_TAGS   (NUM_TAGS),
        .META_WIDTH (META_WIDTH)
    ) u_tag_pool (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .alloc_en     (cmd_fire),
        .alloc_meta   (cmd_meta),
        .free_en      (resp_take),
        .free_tag     (fpu_resp_tag),
        .can_alloc    (can_alloc),
        .alloc_tag    (alloc_tag),
        .free_hit     (tag_hit),
        .free_meta    (resp_meta),
        .any_inflight (any_inflight)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_result <= '0;
            wb_status <= '0;
            wb_meta   <= '0;
        end else if (flush) begin
            wb_valid  <= 1'b0;
        end else if (resp_take) begin
            wb_valid  <= 1'b1;
            wb_result <= fpu_resp_result;
            wb_status <= fpu_resp_status;
            wb_meta   <= resp_meta;
        end else if (wb_fire) begin
            wb_valid  <= 1'b0;
        end
    end

    // A clear in the same cycle as a writeback wins and drops that status.
    always_ff @(posedge clock) begin
        if (reset || fflags_clear) begin
            fflags <= '0;
        end else if (wb_fire) begin
            fflags <= fflags | wb_status;
        end
    end

    assign busy = any_inflight | wb_valid;

`ifdef CVFPU_CLIENT_PERF_EN
    logic [31:0] issued_q;
    logic [31:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (cmd_fire)               issued_q <= issued_q + 32'd1;
            if (cmd_valid && !cmd_ready) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

    no_stray_resp: assert property (@(posedge clock) disable iff (reset)
        resp_fire |-> tag_hit);

endmodule

// File: tb/tb_cvfpu_client.sv
// Directed bench for cvfpu_client: a queue/array-level model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_cvfpu_client;
    import cvfpu_client_pkg::*;

    localparam int WIDTH     = 512;
    localparam int NUM_TAGS  = 4;
    localparam int TAG_WIDTH = $clog2(NUM_TAGS);

    typedef logic [WIDTH-1:0] wide_t;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 cmd_valid, cmd_ready;
    logic [WIDTH-1:0]     cmd_operands_0, cmd_operands_1, cmd_operands_2;
    logic [OP_W-1:0]      cmd_op;
    logic [2:0]           cmd_rm;
    logic [FMT_W-1:0]     cmd_src_fmt, cmd_dst_fmt;
    logic [INT_FMT_W-1:0] cmd_int_fmt;
    logic [SIMD_W-1:0]    cmd_simd_mask;
    logic [META_W-1:0]    cmd_meta;
    logic                 fpu_req_valid, fpu_req_ready;
    logic [WIDTH-1:0]     fpu_req_operands_0, fpu_req_operands_1, fpu_req_operands_2;
    logic [OP_W-1:0]      fpu_req_op;
    logic [2:0]           fpu_req_rm;
    logic [FMT_W-1:0]     fpu_req_src_fmt, fpu_req_dst_fmt;
    logic [INT_FMT_W-1:0] fpu_req_int_fmt;
    logic [SIMD_W-1:0]    fpu_req_simd_mask;
    logic [TAG_WIDTH-1:0] fpu_req_tag;
    logic                 fpu_flush;
    logic                 fpu_resp_valid, fpu_resp_ready;
    logic [WIDTH-1:0]     fpu_resp_result;
    logic [STATUS_W-1:0]  fpu_resp_status;
    logic [TAG_WIDTH-1:0] fpu_resp_tag;
    logic                 wb_valid, wb_ready;
    logic [WIDTH-1:0]     wb_result;
    logic [STATUS_W-1:0]  wb_status;
    logic [META_W-1:0]    wb_meta;
    logic                 flush;
    logic [STATUS_W-1:0]  fflags;
    logic                 fflags_clear;
    logic                 busy;
    logic [31:0]          perf_issued, perf_stall;

    cvfpu_client #(.WIDTH(WIDTH), .NUM_TAGS(NUM_TAGS), .META_WIDTH(META_W)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_operands_0(cmd_operands_0), .cmd_operands_1(cmd_operands_1),
        .cmd_operands_2(cmd_operands_2), .cmd_op(cmd_op), .cmd_rm(cmd_rm),
        .cmd_src_fmt(cmd_src_fmt), .cmd_dst_fmt(cmd_dst_fmt), .cmd_int_fmt(cmd_int_fmt),
        .cmd_simd_mask(cmd_simd_mask), .cmd_meta(cmd_meta),
        .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready),
        .fpu_req_operands_0(fpu_req_operands_0), .fpu_req_operands_1(fpu_req_operands_1),
        .fpu_req_operands_2(fpu_req_operands_2), .fpu_req_op(fpu_req_op),
        .fpu_req_rm(fpu_req_rm), .fpu_req_src_fmt(fpu_req_src_fmt),
        .fpu_req_dst_fmt(fpu_req_dst_fmt), .fpu_req_int_fmt(fpu_req_int_fmt),
        .fpu_req_simd_mask(fpu_req_simd_mask), .fpu_req_tag(fpu_req_tag),
        .fpu_flush(fpu_flush),
        .fpu_resp_valid(fpu_resp_valid), .fpu_resp_ready(fpu_resp_ready),
        .fpu_resp_result(fpu_resp_result), .fpu_resp_status(fpu_resp_status),
        .fpu_resp_tag(fpu_resp_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_status(wb_status), .wb_meta(wb_meta),
        .flush(flush), .fflags(fflags), .fflags_clear(fflags_clear), .busy(busy),
        .perf_issued(perf_issued), .perf_stall(perf_stall)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input wide_t got, input wide_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic wide_t rand_wide();
        wide_t v;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    bit            m_busy [NUM_TAGS];
    meta_t         m_meta [NUM_TAGS];
    bit            m_wbv;
    wide_t         m_wbres;
    logic [4:0]    m_wbst;
    meta_t         m_wbmeta;
    logic [4:0]    m_fflags;
    int unsigned   m_issued, m_stall;

    function automatic int free_tag();
        for (int i = 0; i < NUM_TAGS; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    always @(posedge clock) begin
        int  ft;
        bit  accept, r_fire, w_fire;
        ft     = free_tag();
        accept = fpu_req_ready && ft >= 0 && !flush;
        r_fire = fpu_resp_valid && (!m_wbv || wb_ready);
        w_fire = m_wbv && wb_ready;
        if (reset) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_wbv = 1'b0; m_wbres = '0; m_wbst = '0; m_wbmeta = '0;
            m_fflags = '0; m_issued = 0; m_stall = 0;
        end else begin
            if (fflags_clear) m_fflags = '0;
            else if (w_fire) m_fflags = m_fflags | m_wbst;
            if (cmd_valid && accept) m_issued++;
            if (cmd_valid && !accept) m_stall++;
            if (flush) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_wbv = 1'b0;
            end else begin
                if (w_fire) m_wbv = 1'b0;
                if (r_fire && m_busy[fpu_resp_tag]) begin
                    m_wbv    = 1'b1;
                    m_wbres  = fpu_resp_result;
                    m_wbst   = fpu_resp_status;
                    m_wbmeta = m_meta[fpu_resp_tag];
                    m_busy[fpu_resp_tag] = 1'b0;
                end
                if (cmd_valid && accept) begin
                    m_busy[ft] = 1'b1;
                    m_meta[ft] = cmd_meta;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        int ft;
        bit can, any_busy;
        if (chk_en) begin
            ft  = free_tag();
            can = (ft >= 0);
            any_busy = 1'b0;
            foreach (m_busy[i]) any_busy |= m_busy[i];
            check("cmd_ready", wide_t'(cmd_ready), wide_t'(fpu_req_ready && can && !flush));
            check("req_valid", wide_t'(fpu_req_valid), wide_t'(cmd_valid && can && !flush));
            check("fpu_flush", wide_t'(fpu_flush), wide_t'(flush));
            check("resp_ready", wide_t'(fpu_resp_ready), wide_t'(!m_wbv || wb_ready));
            check("wb_valid", wide_t'(wb_valid), wide_t'(m_wbv));
            check("busy", wide_t'(busy), wide_t'(any_busy || m_wbv));
            check("fflags", wide_t'(fflags), wide_t'(m_fflags));
`ifdef CVFPU_CLIENT_PERF_EN
            check("perf_issued", wide_t'(perf_issued), wide_t'(m_issued));
            check("perf_stall", wide_t'(perf_stall), wide_t'(m_stall));
`else
            check("perf_issued", wide_t'(perf_issued), wide_t'(0));
            check("perf_stall", wide_t'(perf_stall), wide_t'(0));
`endif
            if (cmd_valid && can && !flush) begin
                check("req_tag", wide_t'(fpu_req_tag), wide_t'(ft));
                check("req_op0", fpu_req_operands_0, cmd_operands_0);
                check("req_op2", fpu_req_operands_2, cmd_operands_2);
                check("req_fields",
                      wide_t'({fpu_req_op, fpu_req_rm, fpu_req_src_fmt, fpu_req_dst_fmt,
                               fpu_req_int_fmt, fpu_req_simd_mask, fpu_req_operands_1[7:0]}),
                      wide_t'({cmd_op, cmd_rm, cmd_src_fmt, cmd_dst_fmt,
                               cmd_int_fmt, cmd_simd_mask, cmd_operands_1[7:0]}));
            end
            if (m_wbv) begin
                check("wb_result", wb_result, m_wbres);
                check("wb_status", wide_t'(wb_status), wide_t'(m_wbst));
                check("wb_meta", wide_t'(wb_meta), wide_t'(m_wbmeta));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic probe();
        @(negedge clock);
        #1;
    endtask

    task automatic set_cmd(input logic [9:0] meta);
        cmd_valid      = 1'b1;
        cmd_meta       = meta;
        cmd_operands_0 = rand_wide();
        cmd_operands_1 = rand_wide();
        cmd_operands_2 = rand_wide();
        cmd_op         = 5'($urandom());
        cmd_rm         = 3'($urandom());
        cmd_src_fmt    = 3'($urandom());
        cmd_dst_fmt    = 3'($urandom());
        cmd_int_fmt    = 2'($urandom());
        cmd_simd_mask  = 16'($urandom());
    endtask

    task automatic issue(input logic [9:0] meta);
        set_cmd(meta);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic set_resp(input int tag, input logic [4:0] status);
        fpu_resp_valid  = 1'b1;
        fpu_resp_tag    = TAG_WIDTH'(tag);
        fpu_resp_status = status;
        fpu_resp_result = rand_wide();
    endtask

    task automatic respond(input int tag, input logic [4:0] status);
        set_resp(tag, status);
        step();
        fpu_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; fpu_req_ready = 1'b1; fpu_resp_valid = 1'b0;
        wb_ready = 1'b1; flush = 1'b0; fflags_clear = 1'b0; cmd_meta = '0;
        cmd_operands_0 = '0; cmd_operands_1 = '0; cmd_operands_2 = '0; cmd_op = '0;
        cmd_rm = '0; cmd_src_fmt = '0; cmd_dst_fmt = '0; cmd_int_fmt = '0;
        cmd_simd_mask = '0; fpu_resp_tag = '0; fpu_resp_status = '0; fpu_resp_result = '0;

        // Reset state
        do_reset();
        chk_en = 1'b1;
        probe();
        check("rst_wb_valid", wide_t'(wb_valid), wide_t'(0));
        check("rst_wb_result", wb_result, wide_t'(0));
        check("rst_busy", wide_t'(busy), wide_t'(0));
        check("rst_fflags", wide_t'(fflags), wide_t'(0));
        check("rst_perf", wide_t'({perf_issued, perf_stall}), wide_t'(0));

        // Single op
        step();
        set_cmd(10'h2A5);
        probe();
        check("single_tag", wide_t'(fpu_req_tag), wide_t'(0));
        check("single_req_valid", wide_t'(fpu_req_valid), wide_t'(1));
        step();
        cmd_valid = 1'b0;
        step();
        step();
        respond(0, 5'h01);
        probe();
        check("single_wb_valid", wide_t'(wb_valid), wide_t'(1));
        check("single_wb_meta", wide_t'(wb_meta), wide_t'(10'h2A5));
        check("single_wb_status", wide_t'(wb_status), wide_t'(5'h01));
        step();
        probe();
        check("single_wb_done", wide_t'(wb_valid), wide_t'(0));
        check("single_fflags", wide_t'(fflags), wide_t'(5'h01));
        check("single_busy", wide_t'(busy), wide_t'(0));

        // Pool exhaustion
        step();
        for (int k = 0; k < 4; k++) begin
            set_cmd(10'h100 + 10'(k));
            probe();
            check("pool_tag", wide_t'(fpu_req_tag), wide_t'(k));
            step();
        end
        set_cmd(10'h155);
        probe();
        check("pool_full_ready", wide_t'(cmd_ready), wide_t'(0));
        check("pool_full_valid", wide_t'(fpu_req_valid), wide_t'(0));
        step();
        set_resp(2, 5'h00);
        probe();
        check("pool_free_same_cycle", wide_t'(cmd_ready), wide_t'(0));
        step();
        fpu_resp_valid = 1'b0;
        probe();
        check("pool_reissue_ready", wide_t'(cmd_ready), wide_t'(1));
        check("pool_reissue_tag", wide_t'(fpu_req_tag), wide_t'(2));
        step();
        cmd_valid = 1'b0;
        respond(0, 5'h00);
        respond(1, 5'h00);
        respond(3, 5'h00);
        respond(2, 5'h00);
        probe();
        check("pool_last_meta", wide_t'(wb_meta), wide_t'(10'h155));
        step();

        // Out-of-order completion
        issue(10'h001);
        issue(10'h002);
        issue(10'h003);
        set_resp(2, 5'h00);
        step();
        set_resp(0, 5'h00);
        probe();
        check("ooo_meta0", wide_t'(wb_meta), wide_t'(10'h003));
        step();
        set_resp(1, 5'h00);
        probe();
        check("ooo_meta1", wide_t'(wb_meta), wide_t'(10'h001));
        step();
        fpu_resp_valid = 1'b0;
        probe();
        check("ooo_meta2", wide_t'(wb_meta), wide_t'(10'h002));
        step();

        // Writeback backpressure
        issue(10'h00A);
        issue(10'h00B);
        wb_ready = 1'b0;
        set_resp(0, 5'h00);
        step();
        set_resp(1, 5'h00);
        probe();
        check("bp_resp_ready", wide_t'(fpu_resp_ready), wide_t'(0));
        check("bp_first_meta", wide_t'(wb_meta), wide_t'(10'h00A));
        step();
        step();
        step();
        wb_ready = 1'b1;
        probe();
        check("bp_resp_ready_rise", wide_t'(fpu_resp_ready), wide_t'(1));
        step();
        fpu_resp_valid = 1'b0;
        probe();
        check("bp_second_valid", wide_t'(wb_valid), wide_t'(1));
        check("bp_second_meta", wide_t'(wb_meta), wide_t'(10'h00B));
        step();
        probe();
        check("bp_drained", wide_t'(busy), wide_t'(0));

        // Flush with three in flight and a pending writeback
        step();
        issue(10'h021);
        issue(10'h022);
        issue(10'h023);
        wb_ready = 1'b0;
        respond(0, 5'h08);
        flush = 1'b1;
        set_cmd(10'h024);
        set_resp(1, 5'h02);
        probe();
        check("flush_out", wide_t'(fpu_flush), wide_t'(1));
        check("flush_no_accept", wide_t'(cmd_ready), wide_t'(0));
        step();
        flush = 1'b0; cmd_valid = 1'b0; fpu_resp_valid = 1'b0; wb_ready = 1'b1;
        probe();
        check("flush_wb_valid", wide_t'(wb_valid), wide_t'(0));
        check("flush_busy", wide_t'(busy), wide_t'(0));

        // Flush dropping a response that fires in the flush cycle
        step();
        issue(10'h031);
        issue(10'h032);
        flush = 1'b1;
        set_resp(0, 5'h04);
        probe();
        check("flush_resp_ready", wide_t'(fpu_resp_ready), wide_t'(1));
        step();
        flush = 1'b0; fpu_resp_valid = 1'b0;
        probe();
        check("flush_resp_dropped", wide_t'(wb_valid), wide_t'(0));
        check("flush_busy2", wide_t'(busy), wide_t'(0));
        check("flush_fflags", wide_t'(fflags), wide_t'(5'h01));

        // fflags and perf counters
        step();
        do_reset();
        fpu_req_ready = 1'b0;
        set_cmd(10'h041);
        step();
        step();
        fpu_req_ready = 1'b1;
        step();
        set_cmd(10'h042);
        step();
        set_cmd(10'h043);
        step();
        cmd_valid = 1'b0;
        probe();
`ifdef CVFPU_CLIENT_PERF_EN
        check("perf_issued_3", wide_t'(perf_issued), wide_t'(3));
        check("perf_stall_2", wide_t'(perf_stall), wide_t'(2));
`else
        check("perf_off", wide_t'({perf_issued, perf_stall}), wide_t'(0));
`endif
        step();
        respond(0, 5'h04);
        respond(1, 5'h10);
        respond(2, 5'h00);
        step();
        probe();
        check("fflags_sticky", wide_t'(fflags), wide_t'(5'h14));
        step();
        fflags_clear = 1'b1;
        step();
        fflags_clear = 1'b0;
        probe();
        check("fflags_cleared", wide_t'(fflags), wide_t'(0));
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
